// File: rtl/int_iq_pkg.sv
// Shared types and default widths for the integer issue queue.
package int_iq_pkg;

  // Default widths, matching the dispatch unit.
  localparam int unsigned IQ_DATA_WIDTH   = 32;
  localparam int unsigned IQ_TAG_WIDTH    = 6;
  localparam int unsigned IQ_OPCODE_WIDTH = 4;
  localparam int unsigned IQ_DEPTH        = 4;

  // One reservation-station entry at the default widths.
  typedef struct packed {
    logic                       occupied;
    logic [IQ_OPCODE_WIDTH-1:0] opcode;
    logic [IQ_TAG_WIDTH-1:0]    rd_tag;
    logic [IQ_DATA_WIDTH-1:0]   rs1_data;
    logic [IQ_TAG_WIDTH-1:0]    rs1_tag;
    logic                       rs1_valid;
    logic [IQ_DATA_WIDTH-1:0]   rs2_data;
    logic [IQ_TAG_WIDTH-1:0]    rs2_tag;
    logic                       rs2_valid;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_integer_if.sv
// Dispatch, CDB and issue signals of the integer issue queue.
interface issue_queue_integer_if #(
  parameter int unsigned DATA_WIDTH   = int_iq_pkg::IQ_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH    = int_iq_pkg::IQ_TAG_WIDTH,
  parameter int unsigned OPCODE_WIDTH = int_iq_pkg::IQ_OPCODE_WIDTH
);
  logic                    dispatch_en_integer;
  logic [OPCODE_WIDTH-1:0] dispatch_opcode;
  logic [TAG_WIDTH-1:0]    dispatch_rd_tag;
  logic [DATA_WIDTH-1:0]   dispatch_rs1_data;
  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag;
  logic                    dispatch_rs1_valid;
  logic [DATA_WIDTH-1:0]   dispatch_rs2_data;
  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag;
  logic                    dispatch_rs2_valid;
  logic                    CDB_valid;
  logic [TAG_WIDTH-1:0]    CDB_tag;
  logic [DATA_WIDTH-1:0]   CDB_data;
  logic                    issue_ready;
  logic                    issueque_full_integer;
  logic                    issue_valid;
  logic [OPCODE_WIDTH-1:0] issue_opcode;
  logic [TAG_WIDTH-1:0]    issue_rd_tag;
  logic [DATA_WIDTH-1:0]   issue_rs1_data;
  logic [DATA_WIDTH-1:0]   issue_rs2_data;

  // Dispatch / CDB / ALU side.
  modport master (
    output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
           CDB_valid, CDB_tag, CDB_data, issue_ready,
    input  issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data
  );

  // Issue queue side.
  modport slave (
    input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
           CDB_valid, CDB_tag, CDB_data, issue_ready,
    output issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data
  );
endinterface

// File: rtl/iq_oldest_ready_select.sv
// Priority encoder: one-hot of the lowest-index ready entry plus an any flag.
module iq_oldest_ready_select #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             any
);

  // Walk from the oldest slot; the first ready one wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/issue_queue_integer.sv
// Collapsing reservation-station issue queue for the integer ALU.
module issue_queue_integer
  import int_iq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = IQ_DATA_WIDTH,
  parameter int unsigned TAG_WIDTH    = IQ_TAG_WIDTH,
  parameter int unsigned OPCODE_WIDTH = IQ_OPCODE_WIDTH,
  parameter int unsigned DEPTH        = IQ_DEPTH
) (
  input logic                  clk,
  input logic                  reset,
  issue_queue_integer_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                    occupied;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [TAG_WIDTH-1:0]    rd_tag;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [TAG_WIDTH-1:0]    rs1_tag;
    logic                    rs1_valid;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [TAG_WIDTH-1:0]    rs2_tag;
    logic                    rs2_valid;
  } entry_t;

  // Capture a matching CDB broadcast into any still-pending operand.
  function automatic entry_t wake(entry_t e, logic cdb_valid, logic [TAG_WIDTH-1:0] cdb_tag,
                                  logic [DATA_WIDTH-1:0] cdb_data);
    entry_t r;
    r = e;
    if (e.occupied && cdb_valid) begin
      if (!e.rs1_valid && (e.rs1_tag == cdb_tag)) begin
        r.rs1_data  = cdb_data;
        r.rs1_valid = 1'b1;
      end
      if (!e.rs2_valid && (e.rs2_tag == cdb_tag)) begin
        r.rs2_data  = cdb_data;
        r.rs2_valid = 1'b1;
      end
    end
    return r;
  endfunction

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  entry_t           shifted_up[DEPTH];
  entry_t           new_entry;
  entry_t           sel;
  logic [CntW-1:0]  count_q, count_d, widx;
  logic [DEPTH-1:0] ready, grant;
  logic             any_ready, full, fire, accept;

  // Full comes from registered count only, so same-cycle issue cannot unblock dispatch.
  assign full   = (count_q == CntW'(DEPTH));
  assign fire   = any_ready & bus.issue_ready;
  assign accept = bus.dispatch_en_integer & ~full;

  // Ready bits from registered operand state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = entries_q[i].occupied & entries_q[i].rs1_valid & entries_q[i].rs2_valid;
    end
  end

  iq_oldest_ready_select #(
    .DEPTH(DEPTH)
  ) u_select (
    .ready(ready),
    .grant(grant),
    .any  (any_ready)
  );

  // Mux out the granted entry; all zero when nothing is ready.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = entries_q[i];
    end
  end

  assign bus.issueque_full_integer = full;
  assign bus.issue_valid           = any_ready;
  assign bus.issue_opcode          = sel.opcode;
  assign bus.issue_rd_tag          = sel.rd_tag;
  assign bus.issue_rs1_data        = sel.rs1_data;
  assign bus.issue_rs2_data        = sel.rs2_data;

  // Every slot's younger neighbour, used when an older entry issues.
  always_comb begin
    shifted_up[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted_up[i] = entries_q[i+1];
    end
  end

  // Incoming entry, woken by a same-cycle broadcast.
  always_comb begin
    entry_t e;
    e.occupied  = 1'b1;
    e.opcode    = bus.dispatch_opcode;
    e.rd_tag    = bus.dispatch_rd_tag;
    e.rs1_data  = bus.dispatch_rs1_data;
    e.rs1_tag   = bus.dispatch_rs1_tag;
    e.rs1_valid = bus.dispatch_rs1_valid;
    e.rs2_data  = bus.dispatch_rs2_data;
    e.rs2_tag   = bus.dispatch_rs2_tag;
    e.rs2_valid = bus.dispatch_rs2_valid;
    new_entry   = wake(e, bus.CDB_valid, bus.CDB_tag, bus.CDB_data);
  end

  // Collapse at the issued slot, wake at post-shift positions, append dispatch.
  always_comb begin
    logic   at_or_above;
    entry_t moved;
    at_or_above = 1'b0;
    moved       = '0;
    widx        = fire ? (count_q - 1'b1) : count_q;
    for (int i = 0; i < DEPTH; i++) begin
      at_or_above  = at_or_above | grant[i];
      moved        = (fire && at_or_above) ? shifted_up[i] : entries_q[i];
      entries_d[i] = wake(moved, bus.CDB_valid, bus.CDB_tag, bus.CDB_data);
      if (accept && (CntW'(i) == widx)) entries_d[i] = new_entry;
    end
    count_d = count_q + CntW'(accept) - CntW'(fire);
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_issue_queue_integer.sv
// Self-checking bench for issue_queue_integer against an in-order queue model.
module tb_issue_queue_integer;
  import int_iq_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference: queue ordered oldest first; issue deletes, dispatch appends.
  iq_entry_t model[$];

  issue_queue_integer_if bus ();

  issue_queue_integer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [75:0] dut_out;
  assign dut_out = {bus.issueque_full_integer, bus.issue_valid, bus.issue_opcode,
                    bus.issue_rd_tag, bus.issue_rs1_data, bus.issue_rs2_data};

  function automatic int oldest();
    for (int k = 0; k < model.size(); k++) begin
      if (model[k].rs1_valid && model[k].rs2_valid) return k;
    end
    return -1;
  endfunction

  function automatic iq_entry_t wake_e(iq_entry_t e, logic v, logic [5:0] t, logic [31:0] d);
    iq_entry_t r;
    r = e;
    if (v && !r.rs1_valid && r.rs1_tag == t) begin r.rs1_valid = 1'b1; r.rs1_data = d; end
    if (v && !r.rs2_valid && r.rs2_tag == t) begin r.rs2_valid = 1'b1; r.rs2_data = d; end
    return r;
  endfunction

  function automatic logic [75:0] model_out();
    logic [75:0] r;
    int k;
    k = oldest();
    r = '0;
    r[75] = (model.size() == DEPTH);
    if (k >= 0) begin
      r[74]   = 1'b1;
      r[73:0] = {model[k].opcode, model[k].rd_tag, model[k].rs1_data, model[k].rs2_data};
    end
    return r;
  endfunction

  task automatic model_step();
    int        k;
    bit        pre_full;
    iq_entry_t e;
    if (!reset) begin
      model.delete();
      return;
    end
    pre_full = (model.size() == DEPTH);
    k = oldest();
    if (k >= 0 && bus.issue_ready) model.delete(k);
    for (int i = 0; i < model.size(); i++) begin
      e = model[i];
      model[i] = wake_e(e, bus.CDB_valid, bus.CDB_tag, bus.CDB_data);
    end
    if (bus.dispatch_en_integer && !pre_full) begin
      e.occupied  = 1'b1;
      e.opcode    = bus.dispatch_opcode;
      e.rd_tag    = bus.dispatch_rd_tag;
      e.rs1_data  = bus.dispatch_rs1_data;
      e.rs1_tag   = bus.dispatch_rs1_tag;
      e.rs1_valid = bus.dispatch_rs1_valid;
      e.rs2_data  = bus.dispatch_rs2_data;
      e.rs2_tag   = bus.dispatch_rs2_tag;
      e.rs2_valid = bus.dispatch_rs2_valid;
      model.push_back(wake_e(e, bus.CDB_valid, bus.CDB_tag, bus.CDB_data));
    end
  endtask

  // Inputs change and outputs are sampled around the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.dispatch_en_integer = 1'b0;
    bus.CDB_valid           = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [3:0] op, input logic [5:0] rd,
                                input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                                input logic [31:0] d2, input logic [5:0] t2, input logic v2);
    bus.dispatch_en_integer = 1'b1;
    bus.dispatch_opcode     = op;
    bus.dispatch_rd_tag     = rd;
    bus.dispatch_rs1_data   = d1;
    bus.dispatch_rs1_tag    = t1;
    bus.dispatch_rs1_valid  = v1;
    bus.dispatch_rs2_data   = d2;
    bus.dispatch_rs2_tag    = t2;
    bus.dispatch_rs2_valid  = v2;
  endtask

  task automatic drive_cdb(input logic [5:0] t, input logic [31:0] d);
    bus.CDB_valid = 1'b1;
    bus.CDB_tag   = t;
    bus.CDB_data  = d;
  endtask

  task automatic test_reset();
    drive_dispatch(4'h9, 6'h3F, 32'hDEAD, 6'h0, 1'b1, 32'hBEEF, 6'h0, 1'b1);
    bus.CDB_valid   = 1'b0;
    bus.CDB_tag     = '0;
    bus.CDB_data    = '0;
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (dut_out !== 76'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_out);
    end
    reset = 1'b1;
    drive_dispatch(4'h1, 6'h05, 32'h10, 6'h0, 1'b1, 32'h20, 6'h0, 1'b1);
    tick();
    drive_idle();
    checks++;
    if ({bus.issue_valid, bus.issue_opcode, bus.issue_rd_tag, bus.issue_rs1_data,
         bus.issue_rs2_data} !== {1'b1, 4'h1, 6'h05, 32'h10, 32'h20}) begin
      errors++;
      $display("FAIL first_issue: got %h expected valid op1 rd05 10/20", dut_out);
    end
    tick();
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL reset_drain: got %h expected %h", dut_out, model_out());
    end
  endtask

  task automatic test_wakeup();
    bus.issue_ready = 1'b1;
    drive_dispatch(4'h2, 6'h06, 32'h0, 6'h01, 1'b0, 32'h7, 6'h0, 1'b1);
    tick();
    drive_idle();
    drive_cdb(6'h01, 32'hAF01);
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_early: got valid %b expected 0", bus.issue_valid);
    end
    tick();
    drive_idle();
    checks++;
    if ({bus.issue_valid, bus.issue_rd_tag, bus.issue_rs1_data, bus.issue_rs2_data} !==
        {1'b1, 6'h06, 32'hAF01, 32'h7}) begin
      errors++;
      $display("FAIL wakeup_issue: got %h expected rd06 AF01/7", dut_out);
    end
    tick();
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL wakeup_drain: got %h expected %h", dut_out, model_out());
    end
  endtask

  task automatic test_same_cycle_capture();
    bus.issue_ready = 1'b1;
    drive_dispatch(4'h4, 6'h07, 32'h55, 6'h0, 1'b1, 32'h0, 6'h03, 1'b0);
    drive_cdb(6'h03, 32'hAF03);
    tick();
    drive_idle();
    checks++;
    if ({bus.issue_valid, bus.issue_rd_tag, bus.issue_rs2_data} !== {1'b1, 6'h07, 32'hAF03})
    begin
      errors++;
      $display("FAIL capture_issue: got %h expected rd07 rs2 AF03", dut_out);
    end
    tick();
  endtask

  task automatic test_full_backpressure();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_dispatch(4'h3, 6'(32 + i), $urandom, 6'h0, 1'b1, $urandom, 6'h0, 1'b1);
      tick();
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL fill_%0d: got %h expected %h", i, dut_out, model_out());
      end
    end
    drive_dispatch(4'h5, 6'h2A, 32'h5A5A, 6'h0, 1'b1, 32'hA5A5, 6'h0, 1'b1);
    tick();
    checks++;
    if ({bus.issueque_full_integer, bus.issue_rd_tag} !== {1'b1, 6'h20}) begin
      errors++;
      $display("FAIL fifth_dropped: got %h expected full rd20", dut_out);
    end
    bus.issue_ready = 1'b1;
    tick();
    checks++;
    if ({bus.issueque_full_integer, bus.issue_rd_tag} !== {1'b0, 6'h21}) begin
      errors++;
      $display("FAIL issue_at_full: got %h expected not full rd21", dut_out);
    end
    bus.issue_ready = 1'b0;
    tick();
    drive_idle();
    checks++;
    if (bus.issueque_full_integer !== 1'b1) begin
      errors++;
      $display("FAIL retry_accepted: got full %b expected 1", bus.issueque_full_integer);
    end
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL drain_%0d: got %h expected %h", i, dut_out, model_out());
      end
      if (i == 3) begin
        checks++;
        if (bus.issue_rd_tag !== 6'h2A) begin
          errors++;
          $display("FAIL retry_last: got rd %h expected 2a", bus.issue_rd_tag);
        end
      end
      tick();
    end
  endtask

  task automatic test_oldest_first();
    bus.issue_ready = 1'b0;
    drive_dispatch(4'h6, 6'h11, 32'h0, 6'h02, 1'b0, 32'h1, 6'h0, 1'b1);
    tick();
    drive_dispatch(4'h7, 6'h12, 32'h2, 6'h0, 1'b1, 32'h3, 6'h0, 1'b1);
    tick();
    drive_idle();
    checks++;
    if ({bus.issue_valid, bus.issue_rd_tag} !== {1'b1, 6'h12}) begin
      errors++;
      $display("FAIL oldest_b_first: got %h expected rd12", dut_out);
    end
    bus.issue_ready = 1'b1;
    tick();
    checks++;
    if (bus.issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL a_still_waiting: got valid %b expected 0", bus.issue_valid);
    end
    drive_cdb(6'h02, 32'hAF02);
    tick();
    drive_idle();
    checks++;
    if ({bus.issue_valid, bus.issue_rd_tag, bus.issue_rs1_data} !== {1'b1, 6'h11, 32'hAF02})
    begin
      errors++;
      $display("FAIL a_woken: got %h expected rd11 AF02", dut_out);
    end
    tick();
    checks++;
    if (dut_out !== 76'h0 || model.size() != 0) begin
      errors++;
      $display("FAIL collapse_empty: got %h expected 0", dut_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) < 6) begin
        drive_dispatch(4'($urandom), 6'($urandom), $urandom, 6'($urandom_range(7)),
                       1'($urandom), $urandom, 6'($urandom_range(7)), 1'($urandom));
      end else begin
        bus.dispatch_en_integer = 1'b0;
      end
      if ($urandom_range(1) == 1) drive_cdb(6'($urandom_range(7)), $urandom);
      else bus.CDB_valid = 1'b0;
      bus.issue_ready = ($urandom_range(9) < 6);
      checks++;
      if (dut_out !== model_out()) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", n, dut_out, model_out());
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset_midop();
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(4'h8, 6'(i), $urandom, 6'h0, 1'b1, $urandom, 6'h0, 1'b1);
      tick();
    end
    drive_idle();
    #2 reset = 1'b0;
    model.delete();
    #1;
    checks++;
    if (dut_out !== 76'h0) begin
      errors++;
      $display("FAIL async_clear: got %h expected 0", dut_out);
    end
    bus.issue_ready = 1'b1;
    tick();
    reset = 1'b1;
    checks++;
    if (dut_out !== 76'h0) begin
      errors++;
      $display("FAIL after_release: got %h expected 0", dut_out);
    end
    tick();
    checks++;
    if (dut_out !== model_out()) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h", dut_out, model_out());
    end
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_same_cycle_capture();
    test_full_backpressure();
    test_oldest_first();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_integer.md
Name: issue_queue_integer

Overview:
- Reservation-station style issue queue for the integer unit, directly downstream of the dispatch unit.
- Accepts dispatched integer instructions with operand data or tags, and snoops the CDB to wake up pending operands.
- Issues the oldest ready instruction to the integer ALU through a valid/ready handshake.
- Drives issueque_full_integer back to dispatch.

Parameters:
- DATA_WIDTH, 32, operand data width
- TAG_WIDTH, 6, ROB/rename tag width
- OPCODE_WIDTH, 4, dispatch opcode width
- DEPTH, 4, number of queue entries (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dispatch_en_integer  in  1  dispatch writes one entry this cycle
- dispatch_opcode  in  OPCODE_WIDTH  opcode
- dispatch_rd_tag  in  TAG_WIDTH  destination tag
- dispatch_rs1_data  in  DATA_WIDTH  rs1 value (meaningful when rs1_valid)
- dispatch_rs1_tag  in  TAG_WIDTH  rs1 producer tag
- dispatch_rs1_valid  in  1  rs1 data present
- dispatch_rs2_data  in  DATA_WIDTH  rs2 value
- dispatch_rs2_tag  in  TAG_WIDTH  rs2 producer tag
- dispatch_rs2_valid  in  1  rs2 data present
- CDB_valid  in  1  CDB broadcast valid
- CDB_tag  in  TAG_WIDTH  broadcast tag
- CDB_data  in  DATA_WIDTH  broadcast value
- issue_ready  in  1  integer ALU accepts an instruction
- issueque_full_integer  out  1  queue holds DEPTH entries
- issue_valid  out  1  a ready entry is presented
- issue_opcode  out  OPCODE_WIDTH  issued opcode
- issue_rd_tag  out  TAG_WIDTH  issued destination tag
- issue_rs1_data  out  DATA_WIDTH  issued rs1 value
- issue_rs2_data  out  DATA_WIDTH  issued rs2 value

Behaviour:
- Storage: collapsing queue of DEPTH entries. Entry 0 is the oldest. Each entry holds:
  - occupied bit
  - opcode and rd_tag
  - per operand: data, tag, valid
- Reset (reset=0, async):
  - all occupied bits 0, count 0
  - issueque_full_integer=0, issue_valid=0
  - issue_* data outputs 0
- Full flag: issueque_full_integer = (count==DEPTH), decoded from registered state only. It does not depend on this cycle's issue.
- Dispatch:
  - On the edge with dispatch_en_integer=1 and full=0, the new entry is written to the first free slot after any same-cycle collapse.
  - dispatch_en_integer while full=1 is ignored. Nothing is written or corrupted.
- CDB wakeup:
  - Every edge, each occupied entry with opX_valid=0, CDB_valid=1 and CDB_tag==opX_tag latches CDB_data and sets opX_valid.
  - The same check applies to the incoming dispatch operands: an operand dispatched in the same cycle as its matching broadcast is stored valid with CDB_data.
  - Both operands of one entry may wake on the same broadcast.
- Ready rule: an entry is ready when it is occupied and both operand valid bits are set in registered state.
  - A wakeup or dispatch takes effect one cycle later, so there is a minimum 1-cycle dispatch-to-issue latency.
- Select:
  - issue_valid=1 when any entry is ready.
  - issue_* outputs come combinationally from the lowest-index (oldest) ready entry.
  - Outputs are held stable while issue_valid=1 and issue_ready=0, unless an older entry becomes ready first.
- Issue transfer: on an edge with issue_valid & issue_ready, the selected entry is removed and all younger entries shift down one slot.
- Simultaneous issue + dispatch:
  - count is unchanged.
  - The new entry lands at index count-1 after the collapse.
  - If full was 1, the dispatch is still blocked that cycle. The dispatch unit retries next cycle.
- Simultaneous issue + CDB wakeup: the wakeup applies to entries at their post-shift positions and is never lost.
- count is never negative and never exceeds DEPTH. Issue requires an occupied entry; dispatch requires not full.
- Branch mispredict: the dispatch unit stalls behind unresolved branches, so the queue never holds speculative entries and has no flush port.
- Reset asserted mid-operation clears all entries immediately. Nothing issues until after reset is deasserted.

Decomposition:
- Package int_iq_pkg holds:
  - entry struct typedef (occupied, opcode, rd_tag, rs1/rs2 data/tag/valid)
  - default width constants matching the dispatch unit (DATA_WIDTH 32, TAG 6, OPCODE 4)
- One sub-module, iq_oldest_ready_select: priority encoder taking the DEPTH ready bits and returning the lowest-index one-hot plus an any-valid flag.

Test Plan:
- Reset: hold reset=0 with dispatch_en_integer=1. Expect all outputs 0. After release, dispatch {op 4'h1, rd 6'h05, rs1 valid 32'h10, rs2 valid 32'h20} with issue_ready=1. The next cycle shows issue_valid=1, opcode 1, rd 6'h05, data 10/20.
- Wakeup: dispatch rd 6'h06 with rs1 tag 6'h01 invalid and rs2 valid 32'h7. Then CDB {6'h01, 32'hAF01}. issue_valid rises the cycle after the broadcast with rs1_data=32'hAF01.
- Same-cycle capture: dispatch rs2 tag 6'h03 invalid while CDB {6'h03, 32'hAF03} is valid. The entry issues next cycle with rs2_data=32'hAF03.
- Full and backpressure: issue_ready=0, dispatch 4 entries. issueque_full_integer=1 and a 5th dispatch is dropped. Raise issue_ready for one cycle: entry 0 leaves, full drops, and the 5th retry is accepted.
- Oldest-first: entries A (waiting on tag 6'h02) and B (ready) are queued. B issues first. CDB 6'h02 then wakes A, which issues next, and the queue collapses to count 0.
- Issue + dispatch at full: count=4, issue_ready=1, dispatch_en=1. Count stays 3 after the edge, the new entry is not written, and full=0 the following cycle.
